// File: rtl/pipelined_cla_addsub_if.sv
// Handshake bundle for the pipelined carry-lookahead adder/subtractor.
// The master side is the producer/consumer; the slave side is the adder.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract built from BLOCK-bit carry-lookahead slices.
// One slice per stage; operands skew down the pipe so one op enters per cycle.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    pipelined_cla_addsub_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;

    if (BLOCK < 1 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_param
        $error("WIDTH must be a positive multiple of BLOCK");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_bp;
    logic             w_c0;
    logic             r_ovf;
    logic             r_zero;

    assign w_bp = bus.in_sub ? ~bus.in_b : bus.in_b;
    assign w_c0 = bus.in_sub | bus.in_cin;

    // Each carry is a flat group generate/propagate term, not a ripple chain.
    function automatic logic [BLOCK:0] cla_carries(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             ci
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             gacc;
        logic             pacc;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < BLOCK; i++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int j = i; j >= 0; j--) begin
                gacc = gacc | (pacc & g[j]);
                pacc = pacc & p[j];
            end
            c[i+1] = gacc | (pacc & ci);
        end
        return c;
    endfunction

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int LO = k * BLOCK;
        localparam int HI = LO + BLOCK;

        logic [WIDTH-LO-1:0] w_a;
        logic [WIDTH-LO-1:0] w_b;
        logic                w_ci;
        logic                w_vi;
        logic [BLOCK:0]      w_c;
        logic [BLOCK-1:0]    w_s;
        logic [HI-1:0]       w_sum;
        logic                r_v;
        logic                r_co;
        logic [HI-1:0]       r_s;

        assign w_c = cla_carries(w_a[BLOCK-1:0], w_b[BLOCK-1:0], w_ci);
        assign w_s = w_a[BLOCK-1:0] ^ w_b[BLOCK-1:0] ^ w_c[BLOCK-1:0];

        if (k == 0) begin : g_src
            assign w_a   = bus.in_a;
            assign w_b   = w_bp;
            assign w_ci  = w_c0;
            assign w_vi  = bus.in_valid;
            assign w_sum = w_s;
        end else begin : g_src
            assign w_a   = g_stg[k-1].g_fwd.r_a;
            assign w_b   = g_stg[k-1].g_fwd.r_b;
            assign w_ci  = g_stg[k-1].r_co;
            assign w_vi  = g_stg[k-1].r_v;
            assign w_sum = {w_s, g_stg[k-1].r_s};
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_v  <= 1'b0;
                r_co <= 1'b0;
                r_s  <= '0;
            end else if (w_adv) begin
                r_v  <= w_vi;
                r_co <= w_c[BLOCK];
                r_s  <= w_sum;
            end
        end

        // Only the not-yet-summed operand slices travel to later stages.
        if (k < NBLK - 1) begin : g_fwd
            logic [WIDTH-HI-1:0] r_a;
            logic [WIDTH-HI-1:0] r_b;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a[WIDTH-LO-1:BLOCK];
                    r_b <= w_b[WIDTH-LO-1:BLOCK];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
        end else if (w_adv) begin
            r_ovf  <= g_stg[NBLK-1].w_c[BLOCK] ^ g_stg[NBLK-1].w_c[BLOCK-1];
            r_zero <= ~|g_stg[NBLK-1].w_sum;
        end
    end

    assign w_adv         = ~g_stg[NBLK-1].r_v | bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stg[NBLK-1].r_v;
    assign bus.out_sum   = g_stg[NBLK-1].r_s;
    assign bus.out_cout  = g_stg[NBLK-1].r_co;
    assign bus.out_ovf   = r_ovf;
    assign bus.out_zero  = r_zero;
endmodule
